// File: rtl/ddr_rd_arb2.sv
// ddr_rd_arb2 -- two-master round-robin arbiter for the DDR AXI4 read path.
// One master owns the slave port for a whole burst, from the AR handshake
// through the accepted RLAST beat. The R channel is steered to that master
// only. RLAST is checked against the requested burst length, and a mismatch
// raises a sticky error flag that only reset clears.
module ddr_rd_arb2 #(
  parameter int ADDR_W = 30,
  parameter int DATA_W = 256,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  // master 0 (CPU cache / bootloader)
  input  logic [ADDR_W-1:0] m0_araddr,
  input  logic [LEN_W-1:0]  m0_arlen,
  input  logic              m0_arvalid,
  output logic              m0_arready,
  output logic [DATA_W-1:0] m0_rdata,
  output logic [1:0]        m0_rresp,
  output logic              m0_rlast,
  output logic              m0_rvalid,
  input  logic              m0_rready,
  // master 1 (Versat DMA)
  input  logic [ADDR_W-1:0] m1_araddr,
  input  logic [LEN_W-1:0]  m1_arlen,
  input  logic              m1_arvalid,
  output logic              m1_arready,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [1:0]        m1_rresp,
  output logic              m1_rlast,
  output logic              m1_rvalid,
  input  logic              m1_rready,
  // DDR read port
  output logic              s_arid,
  output logic [ADDR_W-1:0] s_araddr,
  output logic [LEN_W-1:0]  s_arlen,
  output logic [2:0]        s_arsize,
  output logic [1:0]        s_arburst,
  output logic              s_arvalid,
  input  logic              s_arready,
  input  logic [DATA_W-1:0] s_rdata,
  input  logic [1:0]        s_rresp,
  input  logic              s_rlast,
  input  logic              s_rvalid,
  output logic              s_rready,
  // status
  output logic              grant,
  output logic              busy,
  output logic              err
);

  localparam int NM = 2;
  // Every beat uses the full bus width.
  localparam logic [2:0] ARSIZE = 3'($clog2(DATA_W / 8));

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t           state_reg;
  logic             grant_reg;
  logic             last_grant_reg;
  logic [LEN_W-1:0] len_q_reg;
  logic [LEN_W-1:0] beat_reg;
  logic             err_reg;

  // Master ports gathered into arrays so routing can be written once per master.
  logic [ADDR_W-1:0] m_araddr [NM];
  logic [LEN_W-1:0]  m_arlen  [NM];
  logic [NM-1:0]     m_arvalid;
  logic [NM-1:0]     m_rready;
  logic [NM-1:0]     m_arready;
  logic [NM-1:0]     m_rvalid;
  logic [NM-1:0]     m_rlast;
  logic [DATA_W-1:0] m_rdata  [NM];
  logic [1:0]        m_rresp  [NM];

  logic addr_phase;
  logic data_phase;
  logic ar_fire;
  logic r_fire;
  logic pick;
  logic len_mismatch;

  assign m_araddr[0]  = m0_araddr;
  assign m_araddr[1]  = m1_araddr;
  assign m_arlen[0]   = m0_arlen;
  assign m_arlen[1]   = m1_arlen;
  assign m_arvalid    = {m1_arvalid, m0_arvalid};
  assign m_rready     = {m1_rready, m0_rready};

  assign m0_arready   = m_arready[0];
  assign m1_arready   = m_arready[1];
  assign m0_rvalid    = m_rvalid[0];
  assign m1_rvalid    = m_rvalid[1];
  assign m0_rlast     = m_rlast[0];
  assign m1_rlast     = m_rlast[1];
  assign m0_rdata     = m_rdata[0];
  assign m1_rdata     = m_rdata[1];
  assign m0_rresp     = m_rresp[0];
  assign m1_rresp     = m_rresp[1];

  assign addr_phase   = (state_reg == ADDR);
  assign data_phase   = (state_reg == DATA);

  // Per-master steering: only the granted master sees the slave handshakes.
  genvar gi;
  generate
    for (gi = 0; gi < NM; gi++) begin : g_route
      logic sel;
      assign sel           = (grant_reg == 1'(gi));
      assign m_arready[gi] = addr_phase && sel && s_arready;
      assign m_rvalid[gi]  = data_phase && sel && s_rvalid;
      assign m_rlast[gi]   = (data_phase && sel) ? s_rlast : 1'b0;
      assign m_rdata[gi]   = (data_phase && sel) ? s_rdata : '0;
      assign m_rresp[gi]   = (data_phase && sel) ? s_rresp : 2'b00;
    end
  endgenerate

  // Slave-side request comes straight from the granted master's held inputs.
  assign s_arvalid = addr_phase;
  assign s_arid    = addr_phase ? grant_reg : 1'b0;
  assign s_araddr  = addr_phase ? m_araddr[grant_reg] : '0;
  assign s_arlen   = addr_phase ? m_arlen[grant_reg] : '0;
  assign s_arsize  = ARSIZE;
  assign s_arburst = 2'b01;
  assign s_rready  = data_phase ? m_rready[grant_reg] : 1'b0;

  assign ar_fire   = addr_phase && s_arready;
  assign r_fire    = data_phase && s_rvalid && s_rready;

  // A beat is wrong when RLAST does not coincide with the final expected beat.
  assign len_mismatch = s_rlast != (beat_reg == len_q_reg);

  assign grant = grant_reg;
  assign busy  = (state_reg != IDLE);
  assign err   = err_reg;

  // Winner selection: a lone requester wins, a tie goes to whoever was not served last.
  always_comb begin
    pick = grant_reg;
    case (m_arvalid)
      2'b01:   pick = 1'b0;
      2'b10:   pick = 1'b1;
      2'b11:   pick = ~last_grant_reg;
      default: pick = grant_reg;
    endcase
  end

  // Burst-ownership FSM: grant in IDLE, forward AR in ADDR, count beats in DATA.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      grant_reg      <= 1'b0;
      last_grant_reg <= 1'b1;
      len_q_reg      <= '0;
      beat_reg       <= '0;
      err_reg        <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (|m_arvalid) begin
            grant_reg <= pick;
            len_q_reg <= m_arlen[pick];
            state_reg <= ADDR;
          end
        end
        ADDR: begin
          // The grant stays put even if the master drops arvalid here.
          if (ar_fire) begin
            beat_reg  <= '0;
            state_reg <= DATA;
          end
        end
        DATA: begin
          if (r_fire) begin
            beat_reg <= beat_reg + LEN_W'(1);
            if (len_mismatch) begin
              err_reg <= 1'b1;
            end
            // Only RLAST ends the burst; a length error never cuts it short.
            if (s_rlast) begin
              last_grant_reg <= grant_reg;
              state_reg      <= IDLE;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ddr_rd_arb2.sv
// Testbench for ddr_rd_arb2: a behavioural slave and two behavioural masters
// driven from scenario tasks, with a reference model that tracks round-robin
// order, expected beat contents and the sticky error flag.
module tb_ddr_rd_arb2;

  localparam int ADDR_W = 30;
  localparam int DATA_W = 256;
  localparam int LEN_W  = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [ADDR_W-1:0] m0_araddr, m1_araddr;
  logic [LEN_W-1:0]  m0_arlen, m1_arlen;
  logic              m0_arvalid, m1_arvalid;
  logic              m0_arready, m1_arready;
  logic [DATA_W-1:0] m0_rdata, m1_rdata;
  logic [1:0]        m0_rresp, m1_rresp;
  logic              m0_rlast, m1_rlast;
  logic              m0_rvalid, m1_rvalid;
  logic              m0_rready, m1_rready;
  logic              s_arid;
  logic [ADDR_W-1:0] s_araddr;
  logic [LEN_W-1:0]  s_arlen;
  logic [2:0]        s_arsize;
  logic [1:0]        s_arburst;
  logic              s_arvalid, s_arready;
  logic [DATA_W-1:0] s_rdata;
  logic [1:0]        s_rresp;
  logic              s_rlast, s_rvalid, s_rready;
  logic              grant, busy, err;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state.
  bit                last_g;
  bit                exp_err;
  logic [DATA_W-1:0] beat_data [32];

  always #5 clk = ~clk;

  ddr_rd_arb2 #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst),
    .m0_araddr(m0_araddr), .m0_arlen(m0_arlen), .m0_arvalid(m0_arvalid), .m0_arready(m0_arready),
    .m0_rdata(m0_rdata), .m0_rresp(m0_rresp), .m0_rlast(m0_rlast), .m0_rvalid(m0_rvalid), .m0_rready(m0_rready),
    .m1_araddr(m1_araddr), .m1_arlen(m1_arlen), .m1_arvalid(m1_arvalid), .m1_arready(m1_arready),
    .m1_rdata(m1_rdata), .m1_rresp(m1_rresp), .m1_rlast(m1_rlast), .m1_rvalid(m1_rvalid), .m1_rready(m1_rready),
    .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize), .s_arburst(s_arburst),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_rdata(s_rdata), .s_rresp(s_rresp),
    .s_rlast(s_rlast), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .grant(grant), .busy(busy), .err(err)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Time advances one cycle; inputs change and outputs are sampled around the negedge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [DATA_W-1:0] rand_word();
    logic [DATA_W-1:0] w;
    for (int k = 0; k < DATA_W / 32; k++) w[k*32 +: 32] = $urandom;
    return w;
  endfunction

  function automatic logic arready_of(input int m);
    return (m == 0) ? m0_arready : m1_arready;
  endfunction
  function automatic logic rvalid_of(input int m);
    return (m == 0) ? m0_rvalid : m1_rvalid;
  endfunction
  function automatic logic rlast_of(input int m);
    return (m == 0) ? m0_rlast : m1_rlast;
  endfunction
  function automatic logic [DATA_W-1:0] rdata_of(input int m);
    return (m == 0) ? m0_rdata : m1_rdata;
  endfunction
  function automatic logic [1:0] rresp_of(input int m);
    return (m == 0) ? m0_rresp : m1_rresp;
  endfunction

  task automatic set_req(input int m, input logic v, input logic [ADDR_W-1:0] a, input logic [LEN_W-1:0] l);
    if (m == 0) begin m0_arvalid = v; m0_araddr = a; m0_arlen = l; end
    else        begin m1_arvalid = v; m1_araddr = a; m1_arlen = l; end
  endtask

  task automatic drop_req(input int m);
    if (m == 0) m0_arvalid = 1'b0; else m1_arvalid = 1'b0;
  endtask

  task automatic set_rready(input int m, input logic r);
    if (m == 0) m0_rready = r; else m1_rready = r;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    s_arready = 1'b0; s_rvalid = 1'b0; s_rlast = 1'b0; s_rdata = '0; s_rresp = 2'b00;
    m0_arvalid = 1'b0; m1_arvalid = 1'b0; m0_rready = 1'b0; m1_rready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    last_g  = 1'b1;
    exp_err = 1'b0;
  endtask

  // Serves one burst for master m acting as the slave. The slave raises rlast on
  // beat index last_at; len is what the master requested. Optionally stalls the
  // master at stall_beat and raises the other master's request at other_beat.
  task automatic drive_burst(input int m, input int len, input int last_at,
                             input int stall_beat, input int stall_cycles,
                             input int other_beat, input int fixed_base,
                             output int wait_cyc);
    logic [DATA_W-1:0] got_q [$];
    logic [ADDR_W-1:0] exp_addr;
    int beat_i, stalls, guard, o;
    bit hold, rdy, stall_now, other_up;
    o = 1 - m;
    exp_addr = (m == 0) ? m0_araddr : m1_araddr;
    for (int i = 0; i < 32; i++)
      beat_data[i] = (fixed_base >= 0) ? DATA_W'(fixed_base + i) : rand_word();

    wait_cyc = 0;
    #1;
    while (s_arvalid !== 1'b1 && wait_cyc < 20) begin tick(); #1; wait_cyc++; end
    n_checks++;
    if (s_arvalid !== 1'b1) begin
      n_fail++;
      $display("FAIL ar_wait: s_arvalid=%b after %0d cycles, required 1", s_arvalid, wait_cyc);
      return;
    end
    n_checks++;
    if (s_arid !== 1'(m) || s_araddr !== exp_addr || s_arlen !== LEN_W'(len) || s_arsize !== 3'd5 || s_arburst !== 2'b01) begin
      n_fail++;
      $display("FAIL ar_fields: id=%0d addr=%h len=%0d size=%0d burst=%0d, required id=%0d addr=%h len=%0d size=5 burst=1",
               s_arid, s_araddr, s_arlen, s_arsize, s_arburst, m, exp_addr, len);
    end
    repeat ($urandom_range(0, 2)) begin
      n_checks++;
      if (m0_arready !== 1'b0 || m1_arready !== 1'b0 || s_arvalid !== 1'b1) begin
        n_fail++;
        $display("FAIL ar_hold: arready0=%b arready1=%b s_arvalid=%b, required 0 0 1", m0_arready, m1_arready, s_arvalid);
      end
      tick(); #1;
    end
    s_arready = 1'b1;
    #1;
    n_checks++;
    if (arready_of(m) !== 1'b1 || arready_of(o) !== 1'b0) begin
      n_fail++;
      $display("FAIL ar_ready: granted=%b other=%b, required 1 0", arready_of(m), arready_of(o));
    end
    tick();
    s_arready = 1'b0;
    drop_req(m);

    beat_i = 0; stalls = 0; guard = 0; hold = 1'b0; other_up = 1'b0;
    while (beat_i <= last_at && guard < 300) begin
      if (beat_i == other_beat && !other_up) begin
        set_req(o, 1'b1, ADDR_W'($urandom), LEN_W'(1));
        other_up = 1'b1;
      end
      stall_now = (beat_i == stall_beat) && (stalls < stall_cycles);
      if (!hold) s_rvalid = stall_now || ($urandom_range(0, 3) != 0);
      s_rdata = s_rvalid ? beat_data[beat_i] : rand_word();
      s_rresp = s_rvalid ? 2'(beat_i) : 2'b00;
      s_rlast = s_rvalid && (beat_i == last_at);
      rdy = stall_now ? 1'b0 : ($urandom_range(0, 3) != 0);
      if (stall_now) stalls++;
      set_rready(m, rdy);
      set_rready(o, 1'($urandom_range(0, 1)));
      #1;
      n_checks++;
      if (rvalid_of(m) !== s_rvalid || rvalid_of(o) !== 1'b0 || s_rready !== rdy) begin
        n_fail++;
        $display("FAIL r_route: beat %0d rvalid=%b other_rvalid=%b s_rready=%b, required %b 0 %b",
                 beat_i, rvalid_of(m), rvalid_of(o), s_rready, s_rvalid, rdy);
      end
      n_checks++;
      if (rdata_of(m) !== s_rdata || rresp_of(m) !== s_rresp || rlast_of(m) !== s_rlast) begin
        n_fail++;
        $display("FAIL r_pass: beat %0d rresp=%0d rlast=%b, required rresp=%0d rlast=%b (data equal=%b)",
                 beat_i, rresp_of(m), rlast_of(m), s_rresp, s_rlast, rdata_of(m) === s_rdata);
      end
      n_checks++;
      if (m0_arready !== 1'b0 || m1_arready !== 1'b0 || s_arvalid !== 1'b0 || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL r_state: arready0=%b arready1=%b s_arvalid=%b busy=%b, required 0 0 0 1",
                 m0_arready, m1_arready, s_arvalid, busy);
      end
      if (rvalid_of(m) === 1'b1 && rdy) got_q.push_back(rdata_of(m));
      if (s_rvalid && rdy) begin
        if ((beat_i == last_at) != (beat_i == len)) exp_err = 1'b1;
        beat_i++;
      end
      hold = s_rvalid && !rdy;
      tick();
      guard++;
    end
    s_rvalid = 1'b0; s_rlast = 1'b0;
    set_rready(0, 1'b0); set_rready(1, 1'b0);
    #1;
    n_checks++;
    if (beat_i != last_at + 1) begin
      n_fail++;
      $display("FAIL r_timeout: %0d beats transferred, required %0d", beat_i, last_at + 1);
    end
    n_checks++;
    if (busy !== 1'b0 || grant !== 1'(m) || err !== exp_err || s_arvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL post_burst: busy=%b grant=%b err=%b s_arvalid=%b, required 0 %0d %b 0",
               busy, grant, err, s_arvalid, m, exp_err);
    end
    n_checks++;
    if (got_q.size() != last_at + 1) begin
      n_fail++;
      $display("FAIL beat_count: master m%0d received %0d beats, required %0d", m, got_q.size(), last_at + 1);
    end
    for (int i = 0; i < got_q.size() && i <= last_at; i++) begin
      n_checks++;
      if (got_q[i] !== beat_data[i]) begin
        n_fail++;
        $display("FAIL beat_data: beat %0d got %h, required %h", i, got_q[i][31:0], beat_data[i][31:0]);
      end
    end
    last_g = 1'(m);
    $display("burst: m%0d addr=%h len=%0d beats=%0d err=%b wait=%0d", m, exp_addr, len, got_q.size(), err, wait_cyc);
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    s_arready = 1'b1; s_rvalid = 1'b1; m0_rready = 1'b1; m1_rready = 1'b1;
    #1;
    n_checks++;
    if (busy !== 1'b0 || grant !== 1'b0 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_status: busy=%b grant=%b err=%b, required 0 0 0", busy, grant, err);
    end
    n_checks++;
    if (s_arvalid !== 1'b0 || s_rready !== 1'b0 || m0_arready !== 1'b0 || m1_arready !== 1'b0 ||
        m0_rvalid !== 1'b0 || m1_rvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_handshake: s_arvalid=%b s_rready=%b arready=%b%b rvalid=%b%b, required all 0",
               s_arvalid, s_rready, m1_arready, m0_arready, m1_rvalid, m0_rvalid);
    end
    n_checks++;
    if (s_araddr !== '0 || s_arlen !== '0 || s_arid !== 1'b0 || s_arsize !== 3'd5 || s_arburst !== 2'b01) begin
      n_fail++;
      $display("FAIL reset_ar: addr=%h len=%0d id=%b size=%0d burst=%0d, required 0 0 0 5 1",
               s_araddr, s_arlen, s_arid, s_arsize, s_arburst);
    end
    tick(); #1;
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_stays: busy=%b with no request, required 0", busy);
    end
    s_arready = 1'b0; s_rvalid = 1'b0; m0_rready = 1'b0; m1_rready = 1'b0;
    $display("reset: status busy=%b grant=%b err=%b", busy, grant, err);
  endtask

  task automatic test_basic();
    int wc;
    set_req(0, 1'b1, 30'h100, LEN_W'(3));
    #1;
    n_checks++;
    if (s_arvalid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL latency_t0: s_arvalid=%b busy=%b in request cycle, required 0 0", s_arvalid, busy);
    end
    tick(); #1;
    n_checks++;
    if (s_arvalid !== 1'b1 || s_arid !== 1'b0) begin
      n_fail++;
      $display("FAIL latency_t1: s_arvalid=%b s_arid=%b one cycle later, required 1 0", s_arvalid, s_arid);
    end
    drive_burst(0, 3, 3, -1, 0, -1, 'hA0, wc);
  endtask

  task automatic test_round_robin();
    int wc;
    do_reset();
    for (int p = 0; p < 8; p++) begin
      int first;
      set_req(0, 1'b1, ADDR_W'($urandom), LEN_W'(0));
      set_req(1, 1'b1, ADDR_W'($urandom), LEN_W'(0));
      first = last_g ? 0 : 1;
      drive_burst(first, 0, 0, -1, 0, -1, -1, wc);
      drive_burst(1 - first, 0, 0, -1, 0, -1, -1, wc);
      n_checks++;
      if (wc != 0) begin
        n_fail++;
        $display("FAIL rr_gap: pair %0d second grant waited %0d cycles, required 0", p, wc);
      end
    end
  endtask

  task automatic test_stall();
    int wc;
    set_req(0, 1'b1, ADDR_W'($urandom), LEN_W'(7));
    drive_burst(0, 7, 7, 4, 3, -1, -1, wc);
  endtask

  task automatic test_contention();
    int wc;
    set_req(0, 1'b1, ADDR_W'($urandom), LEN_W'(5));
    drive_burst(0, 5, 5, -1, 0, 2, -1, wc);
    drive_burst(1, 1, 1, -1, 0, -1, -1, wc);
    n_checks++;
    if (wc != 0) begin
      n_fail++;
      $display("FAIL contend_gap: m1 address waited %0d extra cycles after the idle cycle, required 0", wc);
    end
  endtask

  task automatic test_err();
    int wc;
    // Late rlast: beat len accepted without rlast.
    set_req(1, 1'b1, ADDR_W'($urandom), LEN_W'(2));
    drive_burst(1, 2, 3, -1, 0, -1, -1, wc);
    do_reset();
    #1;
    n_checks++;
    if (err !== 1'b0) begin
      n_fail++;
      $display("FAIL err_clear: err=%b after reset, required 0", err);
    end
    // Early rlast on beat 1 of a 4-beat burst, then a clean burst keeps err set.
    set_req(0, 1'b1, ADDR_W'($urandom), LEN_W'(3));
    drive_burst(0, 3, 1, -1, 0, -1, -1, wc);
    set_req(1, 1'b1, ADDR_W'($urandom), LEN_W'(2));
    drive_burst(1, 2, 2, -1, 0, -1, -1, wc);
  endtask

  task automatic test_reset_mid_burst();
    int wc;
    int k;
    set_req(1, 1'b1, ADDR_W'($urandom), LEN_W'(5));
    #1;
    k = 0;
    while (s_arvalid !== 1'b1 && k < 10) begin tick(); #1; k++; end
    s_arready = 1'b1;
    tick();
    s_arready = 1'b0;
    drop_req(1);
    s_rvalid = 1'b1; m1_rready = 1'b1; s_rlast = 1'b0; s_rdata = rand_word();
    tick();
    tick();
    #1;
    n_checks++;
    if (busy !== 1'b1 || grant !== 1'b1 || err !== exp_err) begin
      n_fail++;
      $display("FAIL pre_rst: busy=%b grant=%b err=%b at beat 2, required 1 1 %b", busy, grant, err, exp_err);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    n_checks++;
    if (busy !== 1'b0 || grant !== 1'b0 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_status: busy=%b grant=%b err=%b, required 0 0 0", busy, grant, err);
    end
    n_checks++;
    if (s_arvalid !== 1'b0 || s_rready !== 1'b0 || m0_rvalid !== 1'b0 || m1_rvalid !== 1'b0 ||
        m0_arready !== 1'b0 || m1_arready !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_handshake: s_arvalid=%b s_rready=%b rvalid=%b%b arready=%b%b, required all 0",
               s_arvalid, s_rready, m1_rvalid, m0_rvalid, m1_arready, m0_arready);
    end
    s_rvalid = 1'b0; m1_rready = 1'b0;
    last_g = 1'b1; exp_err = 1'b0;
    $display("reset mid-burst: busy=%b grant=%b err=%b", busy, grant, err);
    set_req(1, 1'b1, ADDR_W'($urandom), LEN_W'(2));
    drive_burst(1, 2, 2, -1, 0, -1, -1, wc);
  endtask

  task automatic test_random();
    int wc;
    for (int it = 0; it < 12; it++) begin
      int mode, l0, l1, first, lf, ls;
      mode = $urandom_range(0, 2);
      l0 = $urandom_range(0, 15);
      l1 = $urandom_range(0, 15);
      if (mode == 0) begin
        set_req(0, 1'b1, ADDR_W'($urandom), LEN_W'(l0));
        drive_burst(0, l0, l0, $urandom_range(0, l0), $urandom_range(0, 3), -1, -1, wc);
      end else if (mode == 1) begin
        set_req(1, 1'b1, ADDR_W'($urandom), LEN_W'(l1));
        drive_burst(1, l1, l1, $urandom_range(0, l1), $urandom_range(0, 3), -1, -1, wc);
      end else begin
        set_req(0, 1'b1, ADDR_W'($urandom), LEN_W'(l0));
        set_req(1, 1'b1, ADDR_W'($urandom), LEN_W'(l1));
        first = last_g ? 0 : 1;
        lf = (first == 0) ? l0 : l1;
        ls = (first == 0) ? l1 : l0;
        drive_burst(first, lf, lf, -1, 0, -1, -1, wc);
        drive_burst(1 - first, ls, ls, -1, 0, -1, -1, wc);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    m0_araddr = '0; m1_araddr = '0; m0_arlen = '0; m1_arlen = '0;
    m0_arvalid = 1'b0; m1_arvalid = 1'b0; m0_rready = 1'b0; m1_rready = 1'b0;
    s_arready = 1'b0; s_rdata = '0; s_rresp = 2'b00; s_rlast = 1'b0; s_rvalid = 1'b0;
    last_g = 1'b1; exp_err = 1'b0;
    test_reset();
    test_basic();
    test_round_robin();
    test_stall();
    test_contention();
    test_err();
    test_reset_mid_burst();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
